vga_fb_reader: RTL

- Frame-buffer read stage directly upstream of the VGA output block.
- Reads the VGA x/y/video timing from the output block and drives its 12-bit pixel input.
- Reads a double-buffered frame buffer (two banks written by the UART video path) through a fixed-latency read port, with integer upscaling and a border colour outside the image.
- Swaps read/write banks only during vertical blank, under a ready/ack handshake with the writer.

---
 rtl/vga_fb_reader_if.sv | 12 +
 rtl/vga_fb_reader.sv | 83 ++++++++
 2 files changed

// File: rtl/vga_fb_reader_if.sv
// vga_fb_reader_if: frame-buffer read port plus the bank-swap handshake shared by
// the reader (master) and the frame-buffer/writer side (slave).
interface vga_fb_reader_if #(parameter int ADDR_W = 18);
    logic              fb_rd_en;
    logic [ADDR_W-1:0] fb_rd_addr;
    logic [11:0]       fb_rd_data;
    logic              frame_ready;
    logic              frame_ack;
    logic              wr_bank;
    modport master (output fb_rd_en, fb_rd_addr, frame_ack, wr_bank, input fb_rd_data, frame_ready);
    modport slave  (input fb_rd_en, fb_rd_addr, frame_ack, wr_bank, output fb_rd_data, frame_ready);
endinterface

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: prefetches upscaled pixels from a double-buffered frame buffer so they line up
// with the VGA x/y counters, and swaps banks at the start of vertical blank under ready/ack.
module vga_fb_reader #(
    parameter int          H_TOTAL      = 800,
    parameter int          V_TOTAL      = 525,
    parameter int          V_ACTIVE     = 480,
    parameter int          IMG_W        = 320,
    parameter int          IMG_H        = 240,
    parameter int          SCALE_SHIFT  = 1,
    parameter int          FB_LATENCY   = 1,
    parameter int          ADDR_W       = 18,
    parameter logic [11:0] BORDER_COLOR = 12'h000
) (
    input  logic            i_clk25m,
    input  logic            i_rstn_clk25m,
    input  logic [10:0]     i_VGA_x,
    input  logic [10:0]     i_VGA_y,
    input  logic            i_VGA_video,
    vga_fb_reader_if.master io_fb,
    output logic [11:0]     o_pixel_data
);
    localparam logic [11:0]       LOOK    = 12'(FB_LATENCY + 2);
    localparam logic [11:0]       HT      = 12'(H_TOTAL);
    localparam logic [11:0]       VT      = 12'(V_TOTAL);
    localparam logic [11:0]       W_SC    = 12'(IMG_W << SCALE_SHIFT);
    localparam logic [11:0]       H_SC    = 12'(IMG_H << SCALE_SHIFT);
    localparam logic [ADDR_W-1:0] BANK_SZ = ADDR_W'(IMG_W * IMG_H);

    typedef enum logic {S_IDLE, S_PENDING} state_t;
    state_t r_state, w_state_nxt;

    logic [11:0]           w_xs, w_xf, w_ys, w_yf;
    logic                  w_xwrap, w_inside, w_swap_pt, w_swap, w_unused;
    logic [ADDR_W-1:0]     w_addr, r_addr;
    logic                  r_rd_en, r_bank, r_ack;
    logic [FB_LATENCY-1:0] r_dly;

    assign w_unused = i_VGA_video;

    // Fetch L pixels ahead: address register + RAM latency + output register land on x.
    always_comb begin
        w_xs = {1'b0, i_VGA_x} + LOOK;
        w_xwrap = w_xs >= HT;
        w_xf = w_xwrap ? w_xs - HT : w_xs;
        w_ys = {1'b0, i_VGA_y} + {11'b0, w_xwrap};
        w_yf = (w_ys >= VT) ? 12'd0 : w_ys;
        w_inside = (w_xf < W_SC) && (w_yf < H_SC);
        w_addr = (r_bank ? BANK_SZ : '0) + ADDR_W'(w_yf >> SCALE_SHIFT) * ADDR_W'(IMG_W)
               + ADDR_W'(w_xf >> SCALE_SHIFT);
    end

    // A ready landing exactly on the swap cycle is honoured immediately, not deferred a frame.
    always_comb begin
        w_swap_pt = (i_VGA_x == 11'd0) && (i_VGA_y == 11'(V_ACTIVE));
        w_swap = w_swap_pt && ((r_state == S_PENDING) || io_fb.frame_ready);
        w_state_nxt = w_swap ? S_IDLE : (io_fb.frame_ready ? S_PENDING : r_state);
    end

    always_ff @(posedge i_clk25m or negedge i_rstn_clk25m) begin
        if (!i_rstn_clk25m) begin
            r_state      <= S_IDLE;
            r_bank       <= 1'b0;
            r_ack        <= 1'b0;
            r_rd_en      <= 1'b0;
            r_addr       <= '0;
            r_dly        <= '0;
            o_pixel_data <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_bank       <= r_bank ^ w_swap;
            r_ack        <= w_swap;
            r_rd_en      <= w_inside;
            if (w_inside) r_addr <= w_addr;
            r_dly        <= (r_dly << 1) | FB_LATENCY'(r_rd_en);
            o_pixel_data <= r_dly[FB_LATENCY-1] ? io_fb.fb_rd_data : BORDER_COLOR;
        end
    end

    assign io_fb.fb_rd_en   = r_rd_en;
    assign io_fb.fb_rd_addr = r_addr;
    assign io_fb.frame_ack  = r_ack;
    assign io_fb.wr_bank    = ~r_bank;
endmodule
